compute_tile_sched: RTL and testbench

//  Sequences one output tile through compute_core: per K-slice, loads SIZE weight rows into the
//  WS systolic array, streams M activation rows, then waits for the accumulator before the next slice.

---
 rtl/compute_tile_sched.sv | 202 ++++++++++++++++++++
 tb/tb_compute_tile_sched.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/compute_tile_sched.sv
// compute_tile_sched: sequences one output tile through compute_core.
// For each K-slice it loads SIZE weight rows, waits RD_LAT cycles so the
// weights are resident, streams M activation rows, then waits for the core
// to report that the slice has been accumulated.
//
// Handshake: start is a one-cycle request that is only honoured in IDLE;
// done is a one-cycle acknowledge. The over-events from the core are level
// samples that are only acted on in WAIT_ACC. There is no back-pressure,
// so the buffer strobes and the core controls never pause inside a phase.
module compute_tile_sched #(
  parameter int SIZE   = 16,
  parameter int RD_LAT = 1,
  parameter int M_W    = 16,
  parameter int K_W    = 8,
  parameter int WA_W   = 12,
  parameter int IA_W   = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [M_W-1:0]  cfg_m_rows,
  input  logic [K_W-1:0]  cfg_k_tiles,
  output logic            busy,
  output logic            done,
  output logic            wbuf_rd_en,
  output logic [WA_W-1:0] wbuf_rd_addr,
  output logic            ia_rd_en,
  output logic [IA_W-1:0] ia_rd_addr,
  output logic            store_weight_req,
  output logic            ia_row_valid,
  output logic            ia_calc_done,
  output logic            ia_is_init_data,
  input  logic            partial_sum_calc_over,
  input  logic            tile_calc_over,
  output logic [2:0]      dbg_state
);

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_LD_W     = 3'd1,
    ST_LD_DRAIN = 3'd2,
    ST_STREAM   = 3'd3,
    ST_WAIT_ACC = 3'd4,
    ST_FIN      = 3'd5
  } state_t;

  // One shared phase counter: weight row, drain cycle or activation row.
  localparam int CW_SZ = $clog2(SIZE + 1);
  localparam int CW_RD = $clog2(RD_LAT + 1);
  localparam int CW0   = (M_W > CW_SZ) ? M_W : CW_SZ;
  localparam int CW    = (CW0 > CW_RD) ? CW0 : CW_RD;

  localparam logic [CW-1:0] SIZE_M1 = CW'(SIZE - 1);
  localparam logic [CW-1:0] RD_M1   = CW'(RD_LAT - 1);

  state_t          state_q;
  logic [CW-1:0]   cnt_q;
  logic [M_W-1:0]  m_rows_q;
  logic [K_W-1:0]  k_tiles_q;
  logic [K_W-1:0]  k_q;
  logic [WA_W-1:0] wa_q;
  logic [IA_W-1:0] ia_addr_q;
  logic            busy_q;
  logic            done_q;
  logic            wbuf_rd_en_q;
  logic            ia_rd_en_q;
  logic            ia_last_q;
  logic            ia_init_q;

  // Delay lines matching the buffer read latency; index RD_LAT-1 is the output.
  logic [RD_LAT-1:0] w_pipe_q;
  logic [2:0]        ia_pipe_q [RD_LAT];

  logic [CW-1:0]   m_last;
  logic            k_is_last;

  assign m_last    = CW'(m_rows_q) - CW'(1);
  assign k_is_last = (k_q == (k_tiles_q - K_W'(1)));

  // Tile sequencer with registered strobes, addresses and status.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      m_rows_q     <= '0;
      k_tiles_q    <= '0;
      k_q          <= '0;
      wa_q         <= '0;
      ia_addr_q    <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      wbuf_rd_en_q <= 1'b0;
      ia_rd_en_q   <= 1'b0;
      ia_last_q    <= 1'b0;
      ia_init_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            if ((cfg_m_rows != '0) && (cfg_k_tiles != '0)) begin
              m_rows_q     <= cfg_m_rows;
              k_tiles_q    <= cfg_k_tiles;
              k_q          <= '0;
              wa_q         <= '0;
              ia_addr_q    <= '0;
              cnt_q        <= '0;
              busy_q       <= 1'b1;
              wbuf_rd_en_q <= 1'b1;
              state_q      <= ST_LD_W;
            end else begin
              // Empty tile: acknowledge without touching buffers or core.
              done_q <= 1'b1;
            end
          end
        end
        ST_LD_W: begin
          wa_q <= wa_q + WA_W'(1);
          if (cnt_q == SIZE_M1) begin
            wbuf_rd_en_q <= 1'b0;
            cnt_q        <= '0;
            state_q      <= ST_LD_DRAIN;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        ST_LD_DRAIN: begin
          if (cnt_q == RD_M1) begin
            cnt_q      <= '0;
            ia_rd_en_q <= 1'b1;
            ia_last_q  <= (m_last == '0);
            ia_init_q  <= (k_q == '0);
            state_q    <= ST_STREAM;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        ST_STREAM: begin
          ia_addr_q <= ia_addr_q + IA_W'(1);
          if (cnt_q == m_last) begin
            ia_rd_en_q <= 1'b0;
            ia_last_q  <= 1'b0;
            ia_init_q  <= 1'b0;
            cnt_q      <= '0;
            state_q    <= ST_WAIT_ACC;
          end else begin
            ia_last_q <= ((cnt_q + CW'(1)) == m_last);
            cnt_q     <= cnt_q + CW'(1);
          end
        end
        ST_WAIT_ACC: begin
          if (k_is_last) begin
            if (tile_calc_over) begin
              done_q  <= 1'b1;
              state_q <= ST_FIN;
            end
          end else if (partial_sum_calc_over) begin
            k_q          <= k_q + K_W'(1);
            cnt_q        <= '0;
            wbuf_rd_en_q <= 1'b1;
            state_q      <= ST_LD_W;
          end
        end
        ST_FIN: begin
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  // Read-latency delay lines; the IA sideband travels with its row.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_pipe_q <= '0;
      for (int i = 0; i < RD_LAT; i++) ia_pipe_q[i] <= 3'b000;
    end else begin
      w_pipe_q[0]  <= wbuf_rd_en_q;
      ia_pipe_q[0] <= {ia_rd_en_q, ia_rd_en_q & ia_last_q, ia_rd_en_q & ia_init_q};
      for (int i = 1; i < RD_LAT; i++) begin
        w_pipe_q[i]  <= w_pipe_q[i-1];
        ia_pipe_q[i] <= ia_pipe_q[i-1];
      end
    end
  end

  assign busy             = busy_q;
  assign done             = done_q;
  assign wbuf_rd_en       = wbuf_rd_en_q;
  assign wbuf_rd_addr     = wa_q;
  assign ia_rd_en         = ia_rd_en_q;
  assign ia_rd_addr       = ia_addr_q;
  assign store_weight_req = w_pipe_q[RD_LAT-1];
  assign ia_row_valid     = ia_pipe_q[RD_LAT-1][2];
  assign ia_calc_done     = ia_pipe_q[RD_LAT-1][1];
  assign ia_is_init_data  = ia_pipe_q[RD_LAT-1][0];
  assign dbg_state        = state_q;

endmodule

// File: tb/tb_compute_tile_sched.sv
// Bench for compute_tile_sched: two instances (read latency 1 and 3), a
// responsive core model that raises the over-events a chosen number of
// cycles after ia_calc_done, and a timeline model that predicts the cycle
// of every strobe and address from the sequencing rules.
module tb_compute_tile_sched;
  localparam int SIZE = 4;
  localparam int M_W  = 16;
  localparam int K_W  = 8;
  localparam int WA_W = 12;
  localparam int IA_W = 16;
  localparam int LAT0 = 1;
  localparam int LAT1 = 3;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  logic [1:0]     start_v, pso_v, tco_v;
  logic [M_W-1:0] cfg_m;
  logic [K_W-1:0] cfg_k;
  logic [1:0]     busy_v, done_v, wen_v, ien_v, swr_v, irv_v, icd_v, iinit_v;
  logic [WA_W-1:0] wa0, wa1;
  logic [IA_W-1:0] ia0, ia1;
  logic [2:0]      st0, st1;

  compute_tile_sched #(.SIZE(SIZE), .RD_LAT(LAT0), .M_W(M_W), .K_W(K_W), .WA_W(WA_W), .IA_W(IA_W)) u_lat1 (
    .clk(clk), .rst_n(rst_n), .start(start_v[0]), .cfg_m_rows(cfg_m), .cfg_k_tiles(cfg_k),
    .busy(busy_v[0]), .done(done_v[0]), .wbuf_rd_en(wen_v[0]), .wbuf_rd_addr(wa0),
    .ia_rd_en(ien_v[0]), .ia_rd_addr(ia0), .store_weight_req(swr_v[0]), .ia_row_valid(irv_v[0]),
    .ia_calc_done(icd_v[0]), .ia_is_init_data(iinit_v[0]),
    .partial_sum_calc_over(pso_v[0]), .tile_calc_over(tco_v[0]), .dbg_state(st0));

  compute_tile_sched #(.SIZE(SIZE), .RD_LAT(LAT1), .M_W(M_W), .K_W(K_W), .WA_W(WA_W), .IA_W(IA_W)) u_lat3 (
    .clk(clk), .rst_n(rst_n), .start(start_v[1]), .cfg_m_rows(cfg_m), .cfg_k_tiles(cfg_k),
    .busy(busy_v[1]), .done(done_v[1]), .wbuf_rd_en(wen_v[1]), .wbuf_rd_addr(wa1),
    .ia_rd_en(ien_v[1]), .ia_rd_addr(ia1), .store_weight_req(swr_v[1]), .ia_row_valid(irv_v[1]),
    .ia_calc_done(icd_v[1]), .ia_is_init_data(iinit_v[1]),
    .partial_sum_calc_over(pso_v[1]), .tile_calc_over(tco_v[1]), .dbg_state(st1));

  typedef struct packed {
    logic            busy;
    logic            done;
    logic            wen;
    logic [WA_W-1:0] wa;
    logic            ien;
    logic [IA_W-1:0] ia;
    logic            swr;
    logic            irv;
    logic            icd;
    logic            iinit;
  } obs_t;

  int vectors = 0;
  int miscompares = 0;

  function automatic obs_t sample(input int sel);
    obs_t o;
    if (sel == 0) begin
      o = '{busy_v[0], done_v[0], wen_v[0], wa0, ien_v[0], ia0, swr_v[0], irv_v[0], icd_v[0], iinit_v[0]};
    end else begin
      o = '{busy_v[1], done_v[1], wen_v[1], wa1, ien_v[1], ia1, swr_v[1], irv_v[1], icd_v[1], iinit_v[1]};
    end
    return o;
  endfunction

  // ---------------- scoreboard ----------------
  task automatic chk(input string tag, input int observed, input int expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  task automatic cmp_q(input string tag, input int obs_q[$], input int exp_q[$]);
    int n;
    chk({tag, ".count"}, obs_q.size(), exp_q.size());
    n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) chk($sformatf("%s[%0d]", tag, i), obs_q[i], exp_q[i]);
  endtask

  // ---------------- driver + core model ----------------
  // Cycle t=0 is the cycle in which start is high. The core model raises the
  // matching over-event dc cycles after it sees ia_calc_done (dc=0: same cycle).
  // abort_t > 0 pulls rst_n low in that cycle and only checks the outputs drop.
  task automatic run_tile(input int sel, input int m, input int k, input int dc,
                          input bit glitch, input int abort_t, input string name);
    int lat, d, p, tdone, tend, cd_cnt, base, ti, t_glitch;
    int ew_t[$], ew_a[$], esw_t[$], ei_t[$], ei_a[$], erv_t[$], ecd_t[$], einit_t[$], edone_t[$];
    int ow_t[$], ow_a[$], osw_t[$], oi_t[$], oi_a[$], orv_t[$], ocd_t[$], oinit_t[$], odone_t[$];
    int ov_t[$];
    bit ov_tile[$];
    int busy_cnt, busy_first, busy_last;
    obs_t o;
    bit fire_p, fire_t;

    lat = (sel == 0) ? LAT0 : LAT1;
    // D counted from entry to the accumulate wait, i.e. the cycle after the
    // last IA strobe; ia_calc_done trails that entry by lat-1 cycles.
    d = lat - 1 + dc;
    p = SIZE + lat + m + d + 1;
    tdone = (m != 0 && k != 0) ? k * p + 1 : 1;
    tend = tdone + 3;
    t_glitch = 1 + SIZE + lat + 1;

    if (m != 0 && k != 0) begin
      for (int kk = 0; kk < k; kk++) begin
        base = 1 + kk * p;
        for (int r = 0; r < SIZE; r++) begin
          ew_t.push_back(base + r);
          ew_a.push_back((kk * SIZE + r) % (1 << WA_W));
          esw_t.push_back(base + r + lat);
        end
        for (int mm = 0; mm < m; mm++) begin
          ti = base + SIZE + lat + mm;
          ei_t.push_back(ti);
          ei_a.push_back((kk * m + mm) % (1 << IA_W));
          erv_t.push_back(ti + lat);
          if (mm == m - 1) ecd_t.push_back(ti + lat);
          if (kk == 0) einit_t.push_back(ti + lat);
        end
      end
    end
    edone_t.push_back(tdone);

    busy_cnt = 0; busy_first = -1; busy_last = -1; cd_cnt = 0;

    @(negedge clk);
    cfg_m = M_W'(m);
    cfg_k = K_W'(k);
    start_v[sel] = 1'b1;

    for (int t = 1; t <= tend; t++) begin
      @(negedge clk);
      o = sample(sel);
      if (o.wen)   begin ow_t.push_back(t); ow_a.push_back(int'(o.wa)); end
      if (o.swr)   osw_t.push_back(t);
      if (o.ien)   begin oi_t.push_back(t); oi_a.push_back(int'(o.ia)); end
      if (o.irv)   orv_t.push_back(t);
      if (o.icd)   begin
        ocd_t.push_back(t);
        cd_cnt++;
        ov_t.push_back(t + dc);
        ov_tile.push_back(cd_cnt == k);
      end
      if (o.iinit) oinit_t.push_back(t);
      if (o.done)  odone_t.push_back(t);
      if (o.busy) begin
        busy_cnt++;
        if (busy_first < 0) busy_first = t;
        busy_last = t;
      end

      if (abort_t == t) begin
        rst_n = 1'b0;
        #1;
        o = sample(sel);
        chk({name, ".async_reset_outputs"}, $countones(o), 0);
        start_v = '0; pso_v = '0; tco_v = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        return;
      end

      fire_p = 1'b0; fire_t = 1'b0;
      if (ov_t.size() > 0 && ov_t[0] == t) begin
        if (ov_tile[0]) fire_t = 1'b1; else fire_p = 1'b1;
        void'(ov_t.pop_front());
        void'(ov_tile.pop_front());
      end
      if (glitch && t == 2) fire_t = 1'b1;
      start_v[sel] = glitch && (t == t_glitch);
      pso_v[sel]   = fire_p;
      tco_v[sel]   = fire_t;
    end
    start_v[sel] = 1'b0; pso_v[sel] = 1'b0; tco_v[sel] = 1'b0;

    cmp_q({name, ".wbuf_t"}, ow_t, ew_t);
    cmp_q({name, ".wbuf_addr"}, ow_a, ew_a);
    cmp_q({name, ".store_weight_req_t"}, osw_t, esw_t);
    cmp_q({name, ".ia_t"}, oi_t, ei_t);
    cmp_q({name, ".ia_addr"}, oi_a, ei_a);
    cmp_q({name, ".ia_row_valid_t"}, orv_t, erv_t);
    cmp_q({name, ".ia_calc_done_t"}, ocd_t, ecd_t);
    cmp_q({name, ".ia_is_init_t"}, oinit_t, einit_t);
    cmp_q({name, ".latency_done_t"}, odone_t, edone_t);
    if (m != 0 && k != 0) begin
      chk({name, ".busy_first"}, busy_first, 1);
      chk({name, ".busy_last"}, busy_last, tdone);
      chk({name, ".busy_cycles"}, busy_cnt, tdone);
    end else begin
      chk({name, ".busy_cycles"}, busy_cnt, 0);
    end
    repeat (2) @(negedge clk);
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    obs_t o;
    int rs, rm, rk, rd, ab;
    rst_n = 1'b0;
    start_v = '0; pso_v = '0; tco_v = '0;
    cfg_m = '0; cfg_k = '0;
    repeat (3) @(negedge clk);
    o = sample(0);
    chk("reset_outputs_lat1", $countones(o), 0);
    o = sample(1);
    chk("reset_outputs_lat3", $countones(o), 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    run_tile(0, 3, 1, 2, 1'b0, 0, "T1");
    run_tile(0, 2, 3, 1, 1'b0, 0, "T2");
    run_tile(0, 0, 2, 1, 1'b0, 0, "T3_m0");
    run_tile(0, 3, 0, 1, 1'b0, 0, "T3_k0");
    run_tile(0, 3, 1, 2, 1'b1, 0, "T4");
    // Abort in the second IA row of slice 1 (m=3, k=2, dc=1 -> period 10).
    ab = 1 + (SIZE + LAT0 + 3 + (LAT0 - 1 + 1) + 1) + SIZE + LAT0 + 1;
    run_tile(0, 3, 2, 1, 1'b0, ab, "T5_abort");
    run_tile(0, 3, 1, 2, 1'b0, 0, "T5_restart");
    run_tile(0, 1, 2, 0, 1'b0, 0, "edge_m1_same_cycle");
    run_tile(1, 3, 1, 2, 1'b0, 0, "T6_k1");
    run_tile(1, 2, 3, 0, 1'b0, 0, "T6_k3");

    for (int i = 0; i < 12; i++) begin
      rs = $urandom_range(1, 0);
      rm = $urandom_range(5, 1);
      rk = $urandom_range(3, 1);
      rd = $urandom_range(3, 0);
      run_tile(rs, rm, rk, rd, 1'b0, 0, $sformatf("rand%0d", i));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
